// File: rtl/complex_div_arbiter_if.sv
// Shared status type and the requester/divider handshake bundle
// seen by complex_div_arbiter (slave) and its environment (master).
package fpnew_pkg;
  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;
endpackage

interface complex_div_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
) ();
  import fpnew_pkg::*;

  logic [NUM_REQ-1:0][3:0][63:0] req_operands_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [1:0][63:0]              resp_result_o;
  status_t                       resp_status_o;
  logic [NUM_REQ-1:0]            resp_valid_o;
  logic [NUM_REQ-1:0]            resp_ready_i;
  logic [3:0][63:0]              div_operands_o;
  logic                          div_in_valid_o;
  logic                          div_in_ready_i;
  logic [1:0][63:0]              div_result_i;
  status_t                       div_status_i;
  logic                          div_out_valid_i;
  logic                          div_out_ready_o;

  modport slave (
    input  req_operands_i, req_valid_i, resp_ready_i,
    input  div_in_ready_i, div_result_i, div_status_i,
    input  div_out_valid_i,
    output req_ready_o, resp_result_o, resp_status_o,
    output resp_valid_o, div_operands_o, div_in_valid_o,
    output div_out_ready_o
  );

  modport master (
    output req_operands_i, req_valid_i, resp_ready_i,
    output div_in_ready_i, div_result_i, div_status_i,
    output div_out_valid_i,
    input  req_ready_o, resp_result_o, resp_status_o,
    input  resp_valid_o, div_operands_o, div_in_valid_o,
    input  div_out_ready_o
  );
endinterface

// File: rtl/complex_div_arbiter.sv
// Round-robin front end sharing one complex_div pipeline; a tag
// FIFO routes each in-order result back to the requester that issued it.
module complex_div_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  complex_div_arbiter_if.slave  bus,
  input  logic                  flush_i,
  output logic                  div_flush_o,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] tags_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [IW-1:0] gnt, idx, tag;
  logic          found;
  logic          any_req, full, empty;
  logic          in_valid, push, pop;

  // Search starts at rr_q and wraps modulo NUM_REQ.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IW'((32'(rr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid_i[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign any_req  = |bus.req_valid_i;
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign in_valid = rst_ni & any_req & ~full & ~flush_i;
  assign push     = in_valid & bus.div_in_ready_i;
  assign tag      = tags_q[rptr_q];

  assign bus.div_in_valid_o = in_valid;
  assign bus.div_operands_o =
    any_req ? bus.req_operands_i[gnt] : '0;

  always_comb begin
    bus.req_ready_o      = '0;
    bus.req_ready_o[gnt] = push;
  end

  always_comb begin
    bus.resp_valid_o = '0;
    if (rst_ni && !empty) begin
      bus.resp_valid_o[tag] = bus.div_out_valid_i & ~flush_i;
    end
  end

  // With nothing in flight, drain strays instead of stalling the divider.
  assign bus.div_out_ready_o =
    !rst_ni ? 1'b0 :
    empty   ? 1'b1 :
              bus.resp_ready_i[tag];

  assign pop = ~empty & bus.div_out_valid_i
             & bus.div_out_ready_o;

  assign bus.resp_result_o = bus.div_result_i;
  assign bus.resp_status_o = bus.div_status_i;

  assign div_flush_o = flush_i;
  assign busy_o      = ~empty;
  assign err_o       = err_q;

  always_comb begin
    rr_d = rr_q;
    if (push) begin
      rr_d = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (empty & bus.div_out_valid_i & ~flush_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else if (flush_i) begin
      rr_q   <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (push) begin
        tags_q[wptr_q] <= gnt;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_complex_div_arbiter.sv
// Directed bench for complex_div_arbiter with NUM_REQ=2, DEPTH=8;
// the divider side is driven by hand with fixed latencies.
module tb_complex_div_arbiter;
  import fpnew_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  logic div_flush;
  logic busy;
  logic err;

  int nvec = 0;
  int nerr = 0;
  int issued;
  int cnt0, cnt1;

  logic [3:0][63:0] op_a, op_b;
  logic [1:0][63:0] res;

  complex_div_arbiter_if #(.NUM_REQ(2)) bus ();

  complex_div_arbiter #(
    .NUM_REQ(2),
    .DEPTH  (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .flush_i    (flush),
    .div_flush_o(div_flush),
    .busy_o     (busy),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    op_a = {64'h0, 64'h0, 64'h0, 64'h3FF0000000000000};
    op_b = {64'hB2, 64'hA2, 64'hB1, 64'hA1};
    rst_n = 1'b0;
    flush = 1'b0;
    bus.req_operands_i  = '0;
    bus.req_valid_i     = '0;
    bus.resp_ready_i    = 2'b11;
    bus.div_in_ready_i  = 1'b1;
    bus.div_result_i    = '0;
    bus.div_status_i    = status_t'(5'b0);
    bus.div_out_valid_i = 1'b0;
    tick();
    tick();

    // outputs held low while in reset
    bus.req_valid_i = 2'b11;
    bus.div_out_valid_i = 1'b1;
    flush = 1'b1;
    #1;
    chk("rst_req_ready", bus.req_ready_o, 2'b00);
    chk("rst_in_valid", bus.div_in_valid_o, 1'b0);
    chk("rst_resp_valid", bus.resp_valid_o, 2'b00);
    chk("rst_out_ready", bus.div_out_ready_o, 1'b0);
    chk("rst_div_flush", div_flush, 1'b1);
    flush = 1'b0;
    bus.div_out_valid_i = 1'b0;
    bus.req_valid_i = 2'b00;
    tick();
    rst_n = 1'b1;
    #1;
    chk("init_busy", busy, 1'b0);
    chk("init_err", err, 1'b0);
    chk("init_out_ready", bus.div_out_ready_o, 1'b1);
    tick();

    // single requester, 3-cycle divider
    bus.req_operands_i[0] = op_a;
    bus.req_valid_i = 2'b01;
    #1;
    chk("s_req_ready", bus.req_ready_o, 2'b01);
    chk("s_in_valid", bus.div_in_valid_o, 1'b1);
    chk("s_operands", bus.div_operands_o, op_a);
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    chk("s_busy", busy, 1'b1);
    chk("s_no_resp", bus.resp_valid_o, 2'b00);
    tick();
    tick();
    res = {64'h0, 64'h3FF0000000000000};
    bus.div_result_i = res;
    bus.div_status_i = status_t'(5'b00001);
    bus.div_out_valid_i = 1'b1;
    #1;
    chk("s_resp_valid", bus.resp_valid_o, 2'b01);
    chk("s_resp_result", bus.resp_result_o, res);
    chk("s_resp_status", bus.resp_status_o, 5'b00001);
    chk("s_out_ready", bus.div_out_ready_o, 1'b1);
    tick();
    bus.div_out_valid_i = 1'b0;
    #1;
    chk("s_idle", busy, 1'b0);
    chk("s_err", err, 1'b0);

    // idle flush returns the pointer to requester 0
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // fairness: 8 issues alternate 0,1,0,1...
    bus.req_operands_i[0] = op_a;
    bus.req_operands_i[1] = op_b;
    bus.req_valid_i = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("f_grant", bus.req_ready_o,
          (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("f_operands", bus.div_operands_o,
          (k % 2 == 0) ? op_a : op_b);
      tick();
    end
    bus.req_valid_i = 2'b00;
    cnt0 = 0;
    cnt1 = 0;
    bus.div_out_valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      res = {64'(k + 16), 64'(k)};
      bus.div_result_i = res;
      #1;
      chk("f_route", bus.resp_valid_o,
          (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("f_result", bus.resp_result_o, res);
      if (bus.resp_valid_o[0]) cnt0++;
      if (bus.resp_valid_o[1]) cnt1++;
      tick();
    end
    bus.div_out_valid_i = 1'b0;
    #1;
    chk("f_cnt0", 32'(cnt0), 32'd4);
    chk("f_cnt1", 32'(cnt1), 32'd4);
    chk("f_idle", busy, 1'b0);

    // full FIFO: divider never answers
    issued = 0;
    bus.req_valid_i = 2'b01;
    for (int k = 0; k < 11; k++) begin
      #1;
      if (bus.req_ready_o[0]) issued++;
      tick();
    end
    #1;
    chk("full_issues", 32'(issued), 32'd8);
    chk("full_ready", bus.req_ready_o, 2'b00);
    chk("full_in_valid", bus.div_in_valid_o, 1'b0);
    bus.div_out_valid_i = 1'b1;
    #1;
    chk("full_pop_block", bus.req_ready_o, 2'b00);
    chk("full_pop_resp", bus.resp_valid_o, 2'b01);
    tick();
    bus.div_out_valid_i = 1'b0;
    #1;
    chk("full_resume", bus.req_ready_o, 2'b01);
    tick();
    bus.req_valid_i = 2'b00;
    bus.div_out_valid_i = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    bus.div_out_valid_i = 1'b0;
    #1;
    chk("full_drained", busy, 1'b0);
    chk("full_err", err, 1'b0);

    // backpressure: head tag 1 held while not ready
    bus.req_valid_i = 2'b10;
    #1;
    chk("bp_grant", bus.req_ready_o, 2'b10);
    tick();
    bus.req_valid_i = 2'b00;
    bus.resp_ready_i = 2'b00;
    bus.div_out_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", bus.resp_valid_o, 2'b10);
      chk("bp_stall", bus.div_out_ready_o, 1'b0);
      chk("bp_busy", busy, 1'b1);
      tick();
    end
    bus.resp_ready_i = 2'b01;
    #1;
    chk("bp_wrong_ready", bus.div_out_ready_o, 1'b0);
    bus.resp_ready_i = 2'b10;
    #1;
    chk("bp_go", bus.div_out_ready_o, 1'b1);
    tick();
    bus.div_out_valid_i = 1'b0;
    bus.resp_ready_i = 2'b11;
    #1;
    chk("bp_popped", busy, 1'b0);

    // flush with 3 in flight
    bus.req_valid_i = 2'b11;
    for (int k = 0; k < 3; k++) tick();
    bus.req_valid_i = 2'b01;
    bus.div_out_valid_i = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_busy", busy, 1'b1);
    chk("fl_div_flush", div_flush, 1'b1);
    chk("fl_resp", bus.resp_valid_o, 2'b00);
    chk("fl_ready", bus.req_ready_o, 2'b00);
    chk("fl_in_valid", bus.div_in_valid_o, 1'b0);
    tick();
    flush = 1'b0;
    bus.req_valid_i = 2'b00;
    bus.div_out_valid_i = 1'b0;
    #1;
    chk("fl_cleared", busy, 1'b0);
    chk("fl_flush_low", div_flush, 1'b0);
    chk("fl_err_hold", err, 1'b0);
    bus.div_out_valid_i = 1'b1;
    #1;
    chk("stray_resp", bus.resp_valid_o, 2'b00);
    chk("stray_drain", bus.div_out_ready_o, 1'b1);
    chk("stray_err_pre", err, 1'b0);
    tick();
    bus.div_out_valid_i = 1'b0;
    #1;
    chk("stray_err", err, 1'b1);
    tick();
    #1;
    chk("err_sticky", err, 1'b1);

    // reset with 4 in flight
    bus.req_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) tick();
    #1;
    chk("r_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("r_ready", bus.req_ready_o, 2'b00);
    chk("r_in_valid", bus.div_in_valid_o, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("r_busy_clr", busy, 1'b0);
    chk("r_err_clr", err, 1'b0);
    chk("r_first", bus.req_ready_o, 2'b01);
    tick();
    #1;
    chk("r_second", bus.req_ready_o, 2'b10);
    bus.req_valid_i = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule

// File: doc/complex_div_arbiter.md
# complex_div_arbiter

Round-robin arbiter that shares one `complex_div` pipeline between `NUM_REQ` requesters, such as several triangular-inverse engines running diagonal reciprocals. It grants one requester per accepted operation and records the requester ID of every in-flight operation in a tag FIFO. Each result is returned only to the requester that issued it. The block sits between the requesters and the divider instance, drives the divider's input and output handshakes, and adds no pipeline latency.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters, minimum 2.
- `DEPTH`, default 8: maximum number of operations in flight in the divider, a power of two.

Ports (clock and reset first):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Synchronous and active-low.
- `req_operands_i`  in  `[NUM_REQ-1:0][3:0][63:0]`  per-requester operands `{b2,a2,b1,a1}`.
- `req_valid_i`  in  `NUM_REQ`  per-requester request valid.
- `req_ready_o`  out  `NUM_REQ`  per-requester request accept; one-hot or zero.
- `resp_result_o`  out  `[1:0][63:0]`  shared result bus `{b,a}`.
- `resp_status_o`  out  `fpnew_pkg::status_t`  shared status bus.
- `resp_valid_o`  out  `NUM_REQ`  per-requester response valid; one-hot or zero.
- `resp_ready_i`  in  `NUM_REQ`  per-requester response accept.
- `div_operands_o`  out  `[3:0][63:0]`  to the divider's `operands_i`.
- `div_in_valid_o`  out  1  to the divider's `in_valid_i`.
- `div_in_ready_i`  in  1  from the divider's `in_ready_o`.
- `div_result_i`  in  `[1:0][63:0]`  from the divider's `result_o`.
- `div_status_i`  in  `fpnew_pkg::status_t`  from the divider's `status_o`.
- `div_out_valid_i`  in  1  from the divider's `out_valid_o`.
- `div_out_ready_o`  out  1  to the divider's `out_ready_i`.
- `flush_i`  in  1  flush request.
- `div_flush_o`  out  1  to the divider's `flush_i`.
- `busy_o`  out  1  high while any operation is in flight.
- `err_o`  out  1  sticky flag: a divider result arrived with no matching tag.

## Operation

Registered state:
- `rr_ptr`: `$clog2(NUM_REQ)` bits.
- Tag FIFO: `DEPTH` entries of `$clog2(NUM_REQ)` bits, with read and write pointers that wrap modulo `DEPTH`.
- `count`: `$clog2(DEPTH)+1` bits.
- `err_o`.

Arbitration (combinational):
- `gnt` is the first index `i` with `req_valid_i[i]=1`, searching `rr_ptr`, `rr_ptr+1`, … and wrapping modulo `NUM_REQ`.
- `div_operands_o = req_operands_i[gnt]`, or all zeros when no request is valid.
- `div_in_valid_o = |req_valid_i & (count != DEPTH) & !flush_i`.
- `req_ready_o[gnt] = div_in_valid_o & div_in_ready_i`. All other bits of `req_ready_o` are 0.

Issue:
- An issue is `div_in_valid_o & div_in_ready_i`.
- On issue, push `gnt` into the tag FIFO and set `rr_ptr <= (gnt == NUM_REQ-1) ? 0 : gnt+1`.
- Without an issue, `rr_ptr` holds.

Return:
- `t` is the tag at the FIFO head.
- If `count != 0`:
  - `resp_valid_o[t] = div_out_valid_i & !flush_i`; all other bits are 0.
  - `div_out_ready_o = resp_ready_i[t]`.
  - `resp_result_o = div_result_i` and `resp_status_o = div_status_i`, both passed through unregistered.
  - A pop occurs on `div_out_valid_i & div_out_ready_o`.
- If `count == 0`:
  - `resp_valid_o = 0`.
  - `div_out_ready_o = 1`, so a stray divider result is drained.
  - A stray `div_out_valid_i` sets `err_o <= 1`.

Counting:
- Push and pop in the same cycle: `count` is unchanged and both FIFO pointers advance.
- Push only: `count+1`. Pop only: `count-1`.

Full FIFO:
- `count == DEPTH` blocks issue even if a pop happens in the same cycle.
- Issue resumes the cycle after `count` drops.

Flush:
- `div_flush_o = flush_i`, combinational.
- While `flush_i=1`: `div_in_valid_o=0`, `req_ready_o=0`, `resp_valid_o=0`.
- On the clock edge with `flush_i=1`: `count <= 0`, both FIFO pointers `<= 0`, `rr_ptr <= 0`. `err_o` is unchanged.
- Results the divider emits after the flush arrive with `count == 0` and set `err_o`.

`busy_o = (count != 0)`.

Reset (`rst_ni=0` at a clock edge):
- `rr_ptr=0`, `count=0`, both FIFO pointers 0, `err_o=0`.
- The reset takes effect the same way mid-operation; in-flight tags are discarded.
- During reset, all combinational valid and ready outputs are forced to 0 except `div_flush_o`, which follows `flush_i`.

## Timing

- Arbitration, grant and ready are combinational in the same cycle as the request. The arbiter adds 0 cycles of latency on both the issue and the return paths.
- Divider latency and ordering are whatever `complex_div` provides. Results must return in issue order; the tag FIFO relies on in-order return.
- The `rr_ptr` update is visible in the cycle after an issue. A requester that holds `req_valid_i` high while another requester is also valid is granted at most every other issue when `NUM_REQ=2`.
- A requester must hold its operands and `req_valid_i` stable until its `req_ready_o` is seen.
- `resp_valid_o[i]` can stay high across cycles while `resp_ready_i[i]=0`. During that stall the divider's output is backpressured, and the result is held by the divider.
- `err_o` rises in the cycle after the stray result and stays high until reset.

## Test plan

- **Single requester:** `req_valid_i=2'b01`, operands `{0,0,0,1.0}`, divider model with 3-cycle latency → `req_ready_o=2'b01` the same cycle. `resp_valid_o=2'b01` 3 cycles later with the model's result. `busy_o` high in between, then 0.
- **Fairness:** both requesters valid continuously for 8 issues, divider always ready → grant sequence 0,1,0,1,0,1,0,1. Each requester receives exactly 4 responses, correctly routed and in order.
- **Full FIFO:** divider never emits results and `DEPTH=8` → exactly 8 issues are accepted. `req_ready_o` stays 0 afterwards. One pop re-enables issue one cycle later.
- **Response backpressure:** head tag is 1 and `resp_ready_i=2'b00` for 5 cycles → `resp_valid_o=2'b10` held and `div_out_ready_o=0`. With `resp_ready_i=2'b10` the pop occurs and `count` decrements.
- **Flush mid-flight:** 3 operations in flight, `flush_i` pulsed for 1 cycle → `div_flush_o` pulses and `count=0`. No `resp_valid_o` appears. A later stray `div_out_valid_i` sets `err_o=1`.
- **Reset mid-operation:** `rst_ni=0` for 1 cycle with 4 operations in flight → afterwards `count=0`, `busy_o=0`, `err_o=0`, and the first grant goes to requester 0 when both requesters are valid.
